// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by PC,
// with a sequential table clear on flush and update/mispredict statistics.
module branch_predictor #(
    parameter int ENTRIES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] decode_pc,
    input  logic [31:0] decode_inst,
    input  logic        decode_valid,
    output logic        predict,
    input  logic        pred_en,
    input  logic        result,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int              IDX       = $clog2(ENTRIES);
    localparam logic [4:0]      OP_BRANCH = 5'b11000;
    localparam logic [1:0]      CNT_INIT  = 2'b01;
    localparam logic [IDX-1:0]  LAST_PTR  = IDX'(ENTRIES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            nxt = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return nxt;
    endfunction

    state_t            state_q;
    logic [IDX-1:0]    ptr_q;
    logic [1:0]        table_q [ENTRIES];
    logic [1:0]        table_d [ENTRIES];
    logic [IDX-1:0]    execute_idx_q;
    logic              execute_pred_q;
    logic [31:0]       branch_count_q;
    logic [31:0]       branch_count_d;
    logic [31:0]       mispredict_count_q;
    logic [31:0]       mispredict_count_d;

    logic [IDX-1:0]    lookup_idx_s;
    logic              is_branch_s;
    logic              predict_s;
    logic              accept_s;
    logic              unused_s;

    assign lookup_idx_s = decode_pc[IDX+1:2];
    assign is_branch_s  = (decode_inst[6:2] == OP_BRANCH);
    assign busy         = (state_q == CLEAR);
    assign accept_s     = pred_en & ~busy;

    // Lookup reads the registered table, so a same-cycle update is seen one cycle later.
    assign predict_s = rst & decode_valid & is_branch_s & table_q[lookup_idx_s][1] & ~busy;
    assign predict   = predict_s;

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

    assign unused_s = ^{decode_pc[31:IDX+2], decode_pc[1:0], decode_inst[31:7], decode_inst[1:0]};

    // Next table and statistics: counter training when idle, sequential re-init while clearing.
    always_comb begin
        table_d            = table_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (accept_s) begin
            table_d[execute_idx_q] = sat_step(table_q[execute_idx_q], result);
            branch_count_d         = branch_count_q + 32'd1;
            if (result != execute_pred_q) begin
                mispredict_count_d = mispredict_count_q + 32'd1;
            end else begin
                mispredict_count_d = mispredict_count_q;
            end
        end else begin
            branch_count_d     = branch_count_q;
            mispredict_count_d = mispredict_count_q;
        end
        if (state_q == CLEAR) begin
            table_d[ptr_q] = CNT_INIT;
        end else begin
            table_d[ptr_q] = table_d[ptr_q];
        end
    end

    // Clear sequencer: flush starts a walk over every entry; further flushes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        state_q <= CLEAR;
                        ptr_q   <= '0;
                    end
                end
                CLEAR: begin
                    ptr_q <= ptr_q + IDX'(1);
                    if (ptr_q == LAST_PTR) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    // Table, execute-stage pipeline registers and statistics counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= CNT_INIT;
            end
            execute_idx_q      <= '0;
            execute_pred_q     <= 1'b0;
            branch_count_q     <= 32'd0;
            mispredict_count_q <= 32'd0;
        end else begin
            table_q            <= table_d;
            execute_idx_q      <= lookup_idx_s;
            execute_pred_q     <= predict_s;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: reference model feeds a scoreboard
// queue per cycle, plus scenario-specific checks for each feature.
module tb_branch_predictor;

    localparam int          ENTRIES = 32;
    localparam logic [31:0] BR      = 32'h0000_0063;
    localparam logic [31:0] ARI     = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] decode_pc;
    logic [31:0] decode_inst;
    logic        decode_valid;
    logic        predict;
    logic        pred_en;
    logic        result;
    logic        flush;
    logic        busy;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    typedef struct packed {
        logic        p;
        logic        b;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;

    logic [1:0]  m_tab [ENTRIES];
    logic        m_busy;
    int          m_ptr;
    logic [4:0]  m_exidx;
    logic        m_expred;
    logic [31:0] m_bc;
    logic [31:0] m_mc;

    logic        obs_pred;
    logic        obs_busy;
    logic [31:0] obs_bc;
    logic [31:0] obs_mc;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk              (clk),
        .rst              (rst),
        .decode_pc        (decode_pc),
        .decode_inst      (decode_inst),
        .decode_valid     (decode_valid),
        .predict          (predict),
        .pred_en          (pred_en),
        .result           (result),
        .flush            (flush),
        .busy             (busy),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] m_step(input logic [1:0] c, input logic t);
        case ({c, t})
            3'b000:  return 2'b00;
            3'b001:  return 2'b01;
            3'b010:  return 2'b00;
            3'b011:  return 2'b10;
            3'b100:  return 2'b01;
            3'b101:  return 2'b11;
            3'b110:  return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    function automatic logic model_pred(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        logic [4:0] idx;
        idx = pc[6:2];
        return v && (inst[6:2] == 5'b11000) && m_tab[idx][1] && !m_busy;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_tab[i] = 2'b01;
        m_busy   = 1'b0;
        m_ptr    = 0;
        m_exidx  = 5'd0;
        m_expred = 1'b0;
        m_bc     = 32'd0;
        m_mc     = 32'd0;
        sb_q.delete();
    endtask

    // One clock of stimulus: expectations pushed at drive time, popped and compared at negedge.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic pe, input logic r, input logic fl);
        exp_t e;
        logic p;
        logic was_busy;
        decode_valid = v;
        decode_pc    = pc;
        decode_inst  = inst;
        pred_en      = pe;
        result       = r;
        flush        = fl;
        p    = model_pred(v, pc, inst);
        e.p  = p;
        e.b  = m_busy;
        e.bc = m_bc;
        e.mc = m_mc;
        sb_q.push_back(e);
        @(negedge clk);
        obs_pred = predict;
        obs_busy = busy;
        obs_bc   = branch_count;
        obs_mc   = mispredict_count;
        e = sb_q.pop_front();
        checks++;
        if (predict !== e.p) begin
            errors++;
            $display("FAIL sb_predict pc=%08h: got %0b expected %0b", pc, predict, e.p);
        end
        checks++;
        if (busy !== e.b) begin
            errors++;
            $display("FAIL sb_busy: got %0b expected %0b", busy, e.b);
        end
        checks++;
        if (branch_count !== e.bc) begin
            errors++;
            $display("FAIL sb_branch_count: got %0d expected %0d", branch_count, e.bc);
        end
        checks++;
        if (mispredict_count !== e.mc) begin
            errors++;
            $display("FAIL sb_mispredict_count: got %0d expected %0d", mispredict_count, e.mc);
        end
        @(posedge clk);
        was_busy = m_busy;
        if (pe && !was_busy) begin
            m_tab[m_exidx] = m_step(m_tab[m_exidx], r);
            m_bc = m_bc + 32'd1;
            if (r != m_expred) m_mc = m_mc + 32'd1;
        end
        if (was_busy) begin
            m_tab[m_ptr] = 2'b01;
            if (m_ptr == ENTRIES - 1) m_busy = 1'b0;
            m_ptr++;
        end else if (fl) begin
            m_busy = 1'b1;
            m_ptr  = 0;
        end
        m_exidx  = pc[6:2];
        m_expred = p;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        decode_valid = 1'b1;
        decode_pc    = 32'h100;
        decode_inst  = BR;
        pred_en = 1'b0;
        result  = 1'b0;
        flush   = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (predict !== 1'b0) begin errors++; $display("FAIL reset_predict: got %0b expected 0", predict); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++;
        if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", branch_count, mispredict_count);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_train();
        cycle(1'b1, 32'h100, BR, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_pred !== 1'b0) begin errors++; $display("FAIL train_initial: got %0b expected 0", obs_pred); end
        cycle(1'b1, 32'h100, BR, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 32'h100, BR, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 32'h100, BR, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_pred !== 1'b1) begin errors++; $display("FAIL train_predict: got %0b expected 1", obs_pred); end
        checks++;
        if (obs_bc !== 32'd2 || obs_mc !== 32'd2) begin
            errors++;
            $display("FAIL train_counters: got %0d/%0d expected 2/2", obs_bc, obs_mc);
        end
        checks++;
        if (dut.table_q[0] !== 2'b11) begin errors++; $display("FAIL train_entry: got %0b expected 11", dut.table_q[0]); end
    endtask

    task automatic test_saturate();
        repeat (3) cycle(1'b1, 32'h100, BR, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 32'h100, BR, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dut.table_q[0] !== 2'b11 || obs_pred !== 1'b1) begin
            errors++;
            $display("FAIL sat_high: got entry %0b pred %0b expected 11/1", dut.table_q[0], obs_pred);
        end
        repeat (4) cycle(1'b1, 32'h100, BR, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h100, BR, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dut.table_q[0] !== 2'b00 || obs_pred !== 1'b0) begin
            errors++;
            $display("FAIL sat_low: got entry %0b pred %0b expected 00/0", dut.table_q[0], obs_pred);
        end
    endtask

    task automatic test_alias();
        repeat (3) cycle(1'b1, 32'h100, BR, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 32'h104, ARI, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_pred !== 1'b0) begin errors++; $display("FAIL alias_ari_104: got %0b expected 0", obs_pred); end
        cycle(1'b1, 32'h100, ARI, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_pred !== 1'b0) begin errors++; $display("FAIL alias_ari_100: got %0b expected 0", obs_pred); end
        cycle(1'b1, 32'h180, BR, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_pred !== 1'b1) begin errors++; $display("FAIL alias_180: got %0b expected 1", obs_pred); end
        cycle(1'b0, 32'h100, BR, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_pred !== 1'b0) begin errors++; $display("FAIL alias_invalid: got %0b expected 0", obs_pred); end
    endtask

    task automatic test_same_cycle();
        cycle(1'b1, 32'h10C, BR, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h10C, BR, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs_pred !== 1'b0) begin errors++; $display("FAIL bypass_same: got %0b expected 0", obs_pred); end
        cycle(1'b1, 32'h10C, BR, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_pred !== 1'b1) begin errors++; $display("FAIL bypass_next: got %0b expected 1", obs_pred); end
    endtask

    task automatic test_flush();
        logic [31:0] bc_ref;
        logic [31:0] mc_ref;
        int          busy_cnt;
        logic        ended;
        bc_ref   = m_bc;
        mc_ref   = m_mc;
        busy_cnt = 0;
        ended    = 1'b0;
        cycle(1'b1, 32'h100, BR, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 100 && !ended; n++) begin
            cycle(1'b1, 32'h100, BR, (n < 30), 1'b1, (n == 5));
            if (obs_busy) busy_cnt++;
            else ended = 1'b1;
        end
        checks++;
        if (!ended || busy_cnt != ENTRIES) begin
            errors++;
            $display("FAIL flush_busy_len: got %0d cycles expected %0d", busy_cnt, ENTRIES);
        end
        checks++;
        if (obs_bc !== bc_ref || obs_mc !== mc_ref) begin
            errors++;
            $display("FAIL flush_counters: got %0d/%0d expected %0d/%0d", obs_bc, obs_mc, bc_ref, mc_ref);
        end
        for (int i = 0; i < ENTRIES; i++) begin
            checks++;
            if (dut.table_q[i] !== 2'b01) begin
                errors++;
                $display("FAIL flush_entry[%0d]: got %0b expected 01", i, dut.table_q[i]);
            end
        end
        cycle(1'b1, 32'h180, BR, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_pred !== 1'b0) begin errors++; $display("FAIL flush_predict: got %0b expected 0", obs_pred); end
    endtask

    task automatic test_reset_mid_clear();
        repeat (3) cycle(1'b1, 32'h150, BR, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 32'h150, BR, 1'b0, 1'b0, 1'b1);
        repeat (10) cycle(1'b1, 32'h150, BR, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midclr_busy: got %0b expected 0", busy); end
        checks++;
        if (predict !== 1'b0) begin errors++; $display("FAIL midclr_predict: got %0b expected 0", predict); end
        checks++;
        if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
            errors++;
            $display("FAIL midclr_counters: got %0d/%0d expected 0/0", branch_count, mispredict_count);
        end
        for (int i = 0; i < ENTRIES; i++) begin
            checks++;
            if (dut.table_q[i] !== 2'b01) begin
                errors++;
                $display("FAIL midclr_entry[%0d]: got %0b expected 01", i, dut.table_q[i]);
            end
        end
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        cycle(1'b1, 32'h150, BR, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h150, BR, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 32'h150, BR, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_pred !== 1'b1 || obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL midclr_resume: got pred %0b busy %0b expected 1/0", obs_pred, obs_busy);
        end
    endtask

    initial begin
        test_reset();
        test_train();
        test_saturate();
        test_alias();
        test_same_cycle();
        test_flush();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 32, meaning the number of 2-bit counter entries (a power of 2, 4..256); IDX = log2(ENTRIES).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port decode_pc  input  32  PC of the instruction currently in decode.
REQ-005 SHALL have port decode_inst  input  32  instruction currently in decode.
REQ-006 SHALL have port decode_valid  input  1  decode stage holds a valid instruction.
REQ-007 SHALL have port predict  output  1  taken prediction for the decode-stage instruction.
REQ-008 SHALL have port pred_en  input  1  a conditional branch resolves in execute this cycle.
REQ-009 SHALL have port result  input  1  the resolved branch outcome (1 = taken), qualified by pred_en.
REQ-010 SHALL have port flush  input  1  single-cycle request to re-initialise the table.
REQ-011 SHALL have port busy  output  1  a table clear is in progress.
REQ-012 SHALL have port branch_count  output  32  number of accepted updates.
REQ-013 SHALL have port mispredict_count  output  32  number of accepted updates whose outcome differed from the prediction.

Function
REQ-014 SHALL index the table with decode_pc[IDX+1:2].
REQ-015 SHALL drive predict = decode_valid AND decode_inst[6:2]==BRANCH opcode (5'b11000) AND table[index][1] AND NOT busy, all combinationally.
REQ-016 SHALL register the decode index and the predict value every cycle into execute_idx and execute_pred; these are the values pred_en and result refer to one cycle later.
REQ-017 SHALL, on an accepted update (pred_en=1, busy=0), move table[execute_idx] one step toward 2'b11 if result=1 and toward 2'b00 if result=0, saturating at 2'b11 and 2'b00.
REQ-018 SHALL increment branch_count by 1 on each accepted update, wrapping from 0xFFFFFFFF to 0.
REQ-019 SHALL increment mispredict_count by 1 on each accepted update where result != execute_pred, wrapping from 0xFFFFFFFF to 0.
REQ-020 SHALL, when an update and a lookup address the same entry in the same cycle, return the pre-update value on predict; the new value is visible from the next cycle.
REQ-021 SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-022 SHALL go from IDLE to CLEAR on flush=1, with the clear pointer set to 0.
REQ-023 SHALL, in CLEAR, write 2'b01 to table[pointer] each cycle and increment the pointer.
REQ-024 SHALL return from CLEAR to IDLE in the cycle after the write to entry ENTRIES-1, so a clear lasts exactly ENTRIES cycles.
REQ-025 SHALL hold busy=1 exactly while in CLEAR.
REQ-026 SHALL ignore updates while busy=1 (no table change, no counter increment).
REQ-027 SHALL ignore flush while in CLEAR (no restart).
REQ-028 SHALL leave branch_count and mispredict_count unchanged by flush.
REQ-029 SHALL not inspect decode_inst or the flush/busy state when deciding whether to accept an update; pred_en alone qualifies it, subject to REQ-026.

Reset
REQ-030 SHALL, while rst=0, immediately set every table entry to 2'b01, the FSM to IDLE, the clear pointer to 0, execute_idx to 0, execute_pred to 0, branch_count to 0, mispredict_count to 0, and busy to 0.
REQ-031 SHALL, while rst=0, drive predict=0 regardless of decode inputs.
REQ-032 SHALL abort an in-progress CLEAR on reset assertion; the full reset state of REQ-030 applies.
REQ-033 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Verification
REQ-034 SHALL cover: after reset, branch at decode_pc=0x100 -> predict=0; two updates with result=1 on that index -> entry 2'b11, predict=1; branch_count=2, mispredict_count=2.
REQ-035 SHALL cover: entry at 2'b11, three updates with result=1 -> stays 2'b11; four updates with result=0 -> saturates at 2'b00.
REQ-036 SHALL cover: decode_pc=0x104 with an ARI opcode while the entry is 2'b11 -> predict=0; decode_pc 0x100 and 0x180 (ENTRIES=32) alias to the same entry.
REQ-037 SHALL cover: same-cycle update taking entry 2'b01->2'b10 with a lookup of the same index -> predict=0 that cycle and 1 the next cycle.
REQ-038 SHALL cover: flush pulse -> busy=1 for exactly 32 cycles, all entries 2'b01 afterwards; pred_en during the clear -> counters unchanged; a second flush during the clear -> no extension.
REQ-039 SHALL cover: rst asserted mid-clear at pointer 10 -> busy=0 and all entries 2'b01 immediately, without waiting for a clock edge.
